// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared widths, partition counts and FSM states for the SAD merge transmitter
`timescale 1ns/1ps
package sad_pkg;

    localparam int SAD_W    = 12;   // one 4x4 SAD
    localparam int LEAF_W   = 12;   // 4x4 SADs are zero-extended to this before merging
    localparam int W4X8     = 13;   // 4x8 and 8x4 field width
    localparam int W8X8     = 14;
    localparam int W8X16    = 15;   // 8x16 and 16x8 field width
    localparam int W16X16   = 16;

    localparam int N4X8     = 32;   // also the 8x4 count
    localparam int N8X8     = 16;
    localparam int N8X16    = 8;    // also the 16x8 count
    localparam int N16X16   = 4;

    localparam int CAND_W   = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUT     = 2'd2
    } state_t;

endpackage

// File: rtl/sad_pair_add.sv
// rtl/sad_pair_add.sv - adds two unsigned SADs into a one-bit-wider sum
`timescale 1ns/1ps
module sad_pair_add #(
    parameter int IN_W = 12
) (
    input  logic [IN_W-1:0] i_a,
    input  logic [IN_W-1:0] i_b,
    output logic [IN_W:0]   o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/sad_merge_tx.sv
// rtl/sad_merge_tx.sv - collects 8 rows of 4x4 SADs and emits merged partition SADs; SAD_TX_CAND_IDX_EN adds out_cand_idx/out_last
`timescale 1ns/1ps
module sad_merge_tx
    import sad_pkg::*;
#(
    parameter int SAD_W    = sad_pkg::SAD_W,
    parameter int NUM_CAND = 1089
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [8*SAD_W-1:0]        in_row,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef SAD_TX_CAND_IDX_EN
    output logic [CAND_W-1:0]         out_cand_idx,
    output logic                      out_last,
`endif
    output logic [N4X8*W4X8-1:0]      SAD4x8,
    output logic [N4X8*W4X8-1:0]      SAD8x4,
    output logic [N8X8*W8X8-1:0]      SAD8x8,
    output logic [N8X16*W8X16-1:0]    SAD8x16,
    output logic [N8X16*W8X16-1:0]    SAD16x8,
    output logic [N16X16*W16X16-1:0]  SAD16x16
);

    localparam logic [CAND_W-1:0] CAND_LAST = CAND_W'(NUM_CAND - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [2:0]               r_beat;
    logic [CAND_W-1:0]        r_cand;
    logic [7:0][8*SAD_W-1:0]  r_rows;
    logic                     w_accept;
    logic                     w_out_hs;

    logic [LEAF_W-1:0]  w_leaf   [8][8];
    logic [W4X8-1:0]    w_s4x8   [N4X8];
    logic [W4X8-1:0]    w_s8x4   [N4X8];
    logic [W8X8-1:0]    w_s8x8   [N8X8];
    logic [W8X16-1:0]   w_s8x16  [N8X16];
    logic [W8X16-1:0]   w_s16x8  [N8X16];
    logic [W16X16-1:0]  w_s16x16 [N16X16];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state and handshake outputs; start overrides every transition
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = COLLECT;
            end
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && r_beat == 3'd7) w_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (start) w_next = IDLE;
    end

    assign w_accept = in_valid && in_ready && !start;
    assign w_out_hs = out_valid && out_ready && !start;

    // beat and candidate counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= 3'd0;
            r_cand <= '0;
        end else if (start) begin
            r_beat <= 3'd0;
            r_cand <= '0;
        end else begin
            if (w_accept) r_beat <= r_beat + 3'd1;
            if (w_out_hs) r_cand <= (r_cand == CAND_LAST) ? '0 : r_cand + CAND_W'(1);
        end
    end

    // row storage, one slot per beat; held untouched while the result is pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_rows         <= '0;
        else if (w_accept) r_rows[r_beat] <= in_row;
    end

`ifdef SAD_TX_CAND_IDX_EN
    assign out_cand_idx = r_cand;
    assign out_last     = (r_cand == CAND_LAST);
`endif

    genvar r, c;
    for (r = 0; r < 8; r++) begin : g_leaf_r
        for (c = 0; c < 8; c++) begin : g_leaf_c
            assign w_leaf[r][c] = LEAF_W'(r_rows[r][c*SAD_W +: SAD_W]);
        end
    end

    for (r = 0; r < 4; r++) begin : g_4x8_r
        for (c = 0; c < 8; c++) begin : g_4x8_c
            sad_pair_add #(.IN_W(LEAF_W)) u_add (
                .i_a(w_leaf[2*r][c]), .i_b(w_leaf[2*r+1][c]), .o_sum(w_s4x8[r*8+c]));
        end
    end

    for (r = 0; r < 8; r++) begin : g_8x4_r
        for (c = 0; c < 4; c++) begin : g_8x4_c
            sad_pair_add #(.IN_W(LEAF_W)) u_add (
                .i_a(w_leaf[r][2*c]), .i_b(w_leaf[r][2*c+1]), .o_sum(w_s8x4[r*4+c]));
        end
    end

    for (r = 0; r < 4; r++) begin : g_8x8_r
        for (c = 0; c < 4; c++) begin : g_8x8_c
            sad_pair_add #(.IN_W(W4X8)) u_add (
                .i_a(w_s4x8[r*8+2*c]), .i_b(w_s4x8[r*8+2*c+1]), .o_sum(w_s8x8[r*4+c]));
        end
    end

    for (r = 0; r < 2; r++) begin : g_8x16_r
        for (c = 0; c < 4; c++) begin : g_8x16_c
            sad_pair_add #(.IN_W(W8X8)) u_add (
                .i_a(w_s8x8[2*r*4+c]), .i_b(w_s8x8[(2*r+1)*4+c]), .o_sum(w_s8x16[r*4+c]));
        end
    end

    for (r = 0; r < 4; r++) begin : g_16x8_r
        for (c = 0; c < 2; c++) begin : g_16x8_c
            sad_pair_add #(.IN_W(W8X8)) u_add (
                .i_a(w_s8x8[r*4+2*c]), .i_b(w_s8x8[r*4+2*c+1]), .o_sum(w_s16x8[r*2+c]));
        end
    end

    for (r = 0; r < 2; r++) begin : g_16x16_r
        for (c = 0; c < 2; c++) begin : g_16x16_c
            sad_pair_add #(.IN_W(W8X16)) u_add (
                .i_a(w_s8x16[r*4+2*c]), .i_b(w_s8x16[r*4+2*c+1]), .o_sum(w_s16x16[r*2+c]));
        end
    end

    genvar i;
    for (i = 0; i < N4X8; i++) begin : g_pack32
        assign SAD4x8[i*W4X8 +: W4X8] = w_s4x8[i];
        assign SAD8x4[i*W4X8 +: W4X8] = w_s8x4[i];
    end
    for (i = 0; i < N8X8; i++) begin : g_pack16
        assign SAD8x8[i*W8X8 +: W8X8] = w_s8x8[i];
    end
    for (i = 0; i < N8X16; i++) begin : g_pack8
        assign SAD8x16[i*W8X16 +: W8X16] = w_s8x16[i];
        assign SAD16x8[i*W8X16 +: W8X16] = w_s16x8[i];
    end
    for (i = 0; i < N16X16; i++) begin : g_pack4
        assign SAD16x16[i*W16X16 +: W16X16] = w_s16x16[i];
    end

endmodule

// File: tb/tb_sad_merge_tx.sv
// tb/tb_sad_merge_tx.sv - directed self-checking bench for sad_merge_tx
`timescale 1ns/1ps
module tb_sad_merge_tx;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [95:0]   in_row;
    logic          out_valid;
    logic          out_ready;
    logic [415:0]  SAD4x8;
    logic [415:0]  SAD8x4;
    logic [223:0]  SAD8x8;
    logic [119:0]  SAD8x16;
    logic [119:0]  SAD16x8;
    logic [63:0]   SAD16x16;
`ifdef SAD_TX_CAND_IDX_EN
    logic [10:0]   out_cand_idx;
    logic          out_last;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int g [8][8];

    always #5 clk = ~clk;

    sad_merge_tx dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef SAD_TX_CAND_IDX_EN
        .out_cand_idx(out_cand_idx), .out_last(out_last),
`endif
        .SAD4x8(SAD4x8), .SAD8x4(SAD8x4), .SAD8x8(SAD8x8),
        .SAD8x16(SAD8x16), .SAD16x8(SAD16x8), .SAD16x16(SAD16x16)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int rsum(input int r0, input int nr, input int c0, input int nc);
        int s = 0;
        for (int r = r0; r < r0 + nr; r++)
            for (int c = c0; c < c0 + nc; c++)
                s += g[r][c];
        return s;
    endfunction

    task automatic send_row(input logic [95:0] row);
        int n = 0;
        in_valid = 1'b1;
        in_row   = row;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_grid(input int nrows);
        logic [95:0] row;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < 8; c++) row[c*12 +: 12] = 12'(g[r][c]);
            send_row(row);
        end
    endtask

    task automatic accept_out();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_wait", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_4x8[%0d]", tag, i), SAD4x8[i*13 +: 13], rsum((i/8)*2, 2, i%8, 1));
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_8x4[%0d]", tag, i), SAD8x4[i*13 +: 13], rsum(i/4, 1, (i%4)*2, 2));
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_8x8[%0d]", tag, i), SAD8x8[i*14 +: 14], rsum((i/4)*2, 2, (i%4)*2, 2));
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_8x16[%0d]", tag, i), SAD8x16[i*15 +: 15], rsum((i/4)*4, 4, (i%4)*2, 2));
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_16x8[%0d]", tag, i), SAD16x8[i*15 +: 15], rsum((i/2)*2, 2, (i%2)*4, 4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_16x16[%0d]", tag, i), SAD16x16[i*16 +: 16], rsum((i/2)*4, 4, (i%2)*4, 4));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov_in", out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s16x16", SAD16x16, 0);
        chk("rst_s4x8_or", |SAD4x8, 0);
`ifdef SAD_TX_CAND_IDX_EN
        chk("rst_idx", out_cand_idx, 0);
`endif

        // all-ones rows
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) g[r][c] = 1;
        send_grid(7);
        chk("t1_ov_early", out_valid, 0);
        for (int c = 0; c < 8; c++) in_row[c*12 +: 12] = 12'd1;
        send_row(in_row);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_in_ready", in_ready, 0);
        chk("t1_4x8_5", SAD4x8[5*13 +: 13], 2);
        chk("t1_8x4_31", SAD8x4[31*13 +: 13], 2);
        chk("t1_8x8_3", SAD8x8[3*14 +: 14], 4);
        chk("t1_8x16_7", SAD8x16[7*15 +: 15], 8);
        chk("t1_16x8_0", SAD16x8[0 +: 15], 8);
        chk("t1_16x16_2", SAD16x16[2*16 +: 16], 16);
        check_all("t1");
        accept_out();
        chk("t1_ov_drop", out_valid, 0);
        chk("t1_ir_back", in_ready, 1);

        // ramp r*8+c, then stall with a beat offered
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) g[r][c] = r*8 + c;
        send_grid(8);
        chk("t2_4x8_0", SAD4x8[0 +: 13], 8);
        chk("t2_8x4_0", SAD8x4[0 +: 13], 1);
        chk("t2_16x16_3", SAD16x16[3*16 +: 16], 792);
        check_all("t2");
        in_valid = 1'b1;
        in_row   = '1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_ov", out_valid, 1);
            chk("stall_ir", in_ready, 0);
            chk("stall_16x16_3", SAD16x16[3*16 +: 16], 792);
            chk("stall_4x8_0", SAD4x8[0 +: 13], 8);
        end
        in_valid = 1'b0;
        accept_out();

        // saturated 4x4 SADs
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) g[r][c] = 4095;
        send_grid(8);
        for (int i = 0; i < 4; i++) chk("t3_16x16", SAD16x16[i*16 +: 16], 65520);
        chk("t3_4x8_0", SAD4x8[0 +: 13], 8190);
        chk("t3_8x8_15", SAD8x8[15*14 +: 14], 16380);
        check_all("t3");
        accept_out();

        // start after 3 beats, with a beat offered alongside start
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) g[r][c] = 100 + r*3 + c;
        send_grid(3);
        start = 1'b1; in_valid = 1'b1; in_row = {8{12'd7}};
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        chk("t4_ir", in_ready, 1);
        chk("t4_ov", out_valid, 0);
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) g[r][c] = (r*3 + c*5) % 17;
        send_grid(8);
        chk("t4_out_valid", out_valid, 1);
        check_all("t4");
`ifdef SAD_TX_CAND_IDX_EN
        chk("t4_idx", out_cand_idx, 0);
`endif
        accept_out();

        // start while a result is pending drops it
        send_grid(8);
        chk("t4b_ov", out_valid, 1);
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b0;
        chk("t4b_ov_drop", out_valid, 0);
        chk("t4b_ir", in_ready, 1);
`ifdef SAD_TX_CAND_IDX_EN
        chk("t4b_idx", out_cand_idx, 0);

        // full candidate sweep and wrap
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) g[r][c] = 0;
        for (int k = 0; k < 1089; k++) begin
            send_grid(8);
            chk("t5_idx", out_cand_idx, k);
            chk("t5_last", out_last, (k == 1088) ? 1 : 0);
            accept_out();
        end
        send_grid(8);
        chk("t5_wrap_idx", out_cand_idx, 0);
        chk("t5_wrap_last", out_last, 0);
        accept_out();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
